ddr_ui_mem_model: RTL and testbench
===================================

// Module: ddr_ui_mem_model
// PURPOSE
//  Responder side of the MIG-style DDR3 user interface (UI) used by our traffic generators.
//  Accepts app_* write/read commands and write data, stores them in an internal word array,
//  and returns read data with fixed latency. Models calibration delay and app_rdy back-pressure.
//  Sits in place of the MIG core for loopback/simulation of UI initiators.
// PARAMETERS
//  DEPTH_LOG2      8    log2 of number of 64-bit words stored (256 words)
//  CALIB_CYCLES    64   cycles after reset before init_calib_complete rises (>=1)
//  RD_LATENCY      4    cycles from read accept edge to app_rd_data_valid (1..16)
//  STALL_PERIOD    16   app_rdy drops 1 cycle every STALL_PERIOD cycles; 0 = never stall
// PORTS
//  clk                  in   1   clock
//  rst                  in   1   asynchronous reset, active-high
//  app_addr             in   32  byte address; word index = app_addr[DEPTH_LOG2+2:3]
//  app_cmd              in   3   3'b000 write, 3'b001 read, others illegal
//  app_en               in   1   command valid
//  app_wdf_data         in   64  write data
//  app_wdf_mask         in   32  bit i (i<8) = 1 masks byte i; bits [31:8] ignored
//  app_wdf_end          in   1   last write-data beat (must equal app_wdf_wren)
//  app_wdf_wren         in   1   write data valid
//  init_calib_complete  out  1   calibration done, sticky until reset
//  app_rdy              out  1   command accepted when app_en & app_rdy
//  app_wdf_rdy          out  1   write-data FIFO ready
//  app_rd_data          out  64  read data
//  app_rd_data_valid    out  1   read data valid, one cycle per accepted read
//  app_rd_data_end      out  1   equals app_rd_data_valid (single-beat bursts)
//  proto_err            out  1   sticky protocol error flag
//  wr_count             out  16  accepted writes, wraps at 16'hFFFF->0
//  rd_count             out  16  accepted reads, wraps
// BEHAVIOUR
//  - Reset: all outputs 0; calib counter, stall counter, read pipeline cleared.
//    Memory array is NOT cleared (RAM). Reset mid-operation drops in-flight reads.
//  - Calib: init_calib_complete rises at cycle CALIB_CYCLES after reset release; then sticky.
//  - app_wdf_rdy = init_calib_complete. app_rdy = init_calib_complete & ~stall, where stall
//    is high 1 cycle when free-running stall counter (counts from calib done) hits
//    STALL_PERIOD-1, then counter restarts at 0.
//  - Accept: acc = app_en & app_rdy, evaluated at posedge; one command per cycle.
//  - Write (acc, cmd 000): requires app_wdf_wren & app_wdf_end & app_wdf_rdy same cycle;
//    unmasked bytes written at word index; wr_count+1. Missing wdf_wren -> write
//    dropped, proto_err set.
//  - app_wdf_wren high without accepted write command in that cycle -> data discarded,
//    proto_err set. app_wdf_end != app_wdf_wren -> proto_err set.
//  - Read (acc, cmd 001): array sampled at accept edge (sees all earlier writes), pushed
//    into RD_LATENCY-stage shift pipeline; accept at edge k -> valid/end/data high in the
//    cycle after edge k+RD_LATENCY-1, one cycle wide. Back-to-back reads return
//    back-to-back, in order. rd_count+1.
//  - Illegal cmd accepted: no memory access, no count, proto_err set.
//  - app_en while app_rdy=0: not accepted, no error; initiator must hold.
//  - Address: addr[2:0] and bits above DEPTH_LOG2+2 ignored (aliasing wrap).
//  - app_rd_data holds last value when valid low.
// TESTING
//  1 Reset release, idle -> calib rises exactly at cycle 64; app_rdy/app_wdf_rdy 0 before.
//  2 Write 0x1122334455667788 @0x08, then read @0x08 -> valid 4 cycles later, same data.
//  3 Write mask 8'h0F over 0xFFFF...FF, word pre-written 0 -> read returns 0xFFFFFFFF00000000.
//  4 200 writes stride 8 with data 0..199, then 200 reads -> data 0..199 in order, counts=200,
//    app_rdy stalls every 16th cycle honored, proto_err=0.
//  5 Write cmd with app_wdf_wren=0; then cmd 3'b010 -> proto_err=1, wr_count unchanged.
//  6 Read @0x0, @0x800 (alias, DEPTH_LOG2=8) then assert rst before return -> no valid
//    pulse; after recalibration, read returns pre-reset contents.

Source files
------------

// File: rtl/ddr_ui_mem_model.sv
// ddr_ui_mem_model
// Responder-side model of a MIG-style DDR3 user interface. Stores 64-bit words
// in an internal array, returns read data after a fixed latency, and models the
// calibration delay and periodic app_rdy back-pressure seen from a real core.
// Protocol violations by the initiator are latched into a sticky flag.

module ddr_ui_mem_model #(
    parameter int DEPTH_LOG2   = 8,
    parameter int CALIB_CYCLES = 64,
    parameter int RD_LATENCY   = 4,
    parameter int STALL_PERIOD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] app_addr,
    input  logic [2:0]  app_cmd,
    input  logic        app_en,
    input  logic [63:0] app_wdf_data,
    input  logic [31:0] app_wdf_mask,
    input  logic        app_wdf_end,
    input  logic        app_wdf_wren,
    output logic        init_calib_complete,
    output logic        app_rdy,
    output logic        app_wdf_rdy,
    output logic [63:0] app_rd_data,
    output logic        app_rd_data_valid,
    output logic        app_rd_data_end,
    output logic        proto_err,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CALIB_W = $clog2(CALIB_CYCLES + 1);
    localparam int STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    localparam logic [CALIB_W-1:0] CALIB_LAST = CALIB_W'(CALIB_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST =
        STALL_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

    typedef enum logic [2:0] {
        CMD_WRITE = 3'b000,
        CMD_READ  = 3'b001
    } ui_cmd_e;

    // Calibration and back-pressure state
    logic                  calib_q, calib_d;
    logic [CALIB_W-1:0]    calib_cnt_q, calib_cnt_d;
    logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                  stall;

    // Command decode
    logic                  acc;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  acc_bad;
    logic                  wr_ok;
    logic                  err_now;
    logic [DEPTH_LOG2-1:0] word_idx;

    // Status and counters
    logic                  proto_err_q, proto_err_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic [15:0]           rd_count_q, rd_count_d;

    // Read return pipeline: one valid bit and one data word per stage
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [63:0]           data_q [RD_LATENCY];
    logic [63:0]           data_d [RD_LATENCY];

    // Storage array
    logic [63:0]           mem_q [DEPTH];

    // Address bits outside the word index and the upper mask bits carry no meaning.
    logic                  unused_bits;
    assign unused_bits = ^{app_addr[31:DEPTH_LOG2+3], app_addr[2:0], app_wdf_mask[31:8]};

    assign word_idx = app_addr[DEPTH_LOG2+2:3];
    assign stall    = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);

    assign init_calib_complete = calib_q;
    assign app_wdf_rdy         = calib_q;
    assign app_rdy             = calib_q & ~stall;
    assign app_rd_data         = data_q[RD_LATENCY-1];
    assign app_rd_data_valid   = vld_q[RD_LATENCY-1];
    assign app_rd_data_end     = vld_q[RD_LATENCY-1];
    assign proto_err           = proto_err_q;
    assign wr_count            = wr_count_q;
    assign rd_count            = rd_count_q;

    // Calibration countdown and free-running stall counter once calibrated
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        calib_d     = calib_q;
        calib_cnt_d = calib_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!calib_q) begin
            if (calib_cnt_q == CALIB_LAST) begin
                calib_d = 1'b1;
            end else begin
                calib_cnt_d = calib_cnt_q + CALIB_W'(1);
            end
        end
        if (calib_q && (STALL_PERIOD != 0)) begin
            stall_cnt_d = (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + STALL_W'(1);
        end
    end

    // Command acceptance, protocol error detection and transaction counters
    always_comb begin
        acc     = app_en & app_rdy;
        acc_wr  = acc & (app_cmd == CMD_WRITE);
        acc_rd  = acc & (app_cmd == CMD_READ);
        acc_bad = acc & ~acc_wr & ~acc_rd;
        wr_ok   = acc_wr & app_wdf_wren & app_wdf_end & app_wdf_rdy;

        // A write without its data beat, a data beat without a write, a
        // mismatched end flag, or an illegal opcode are all initiator errors.
        err_now = (acc_wr & ~app_wdf_wren)
                | (app_wdf_wren & ~acc_wr)
                | (app_wdf_end ^ app_wdf_wren)
                | acc_bad;

        proto_err_d = proto_err_q | err_now;
        wr_count_d  = wr_ok  ? wr_count_q + 16'd1 : wr_count_q;
        rd_count_d  = acc_rd ? rd_count_q + 16'd1 : rd_count_q;
    end

    // Read pipeline: the array is sampled on the accept edge; each data stage
    // only loads when the stage feeding it is valid, so the last stage holds
    // the most recently returned word while valid is low.
    always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        vld_d[0]  = acc_rd;
        if (acc_rd) begin
            data_d[0] = mem_q[word_idx];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Byte-masked write into the storage array
    // NOTE: the array has no reset; its contents survive rst like a real DRAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < 8; b++) begin
                if (!app_wdf_mask[b]) begin
                    mem_q[word_idx][8*b +: 8] <= app_wdf_data[8*b +: 8];
                end
            end
        end
    end

    // Control, status and read-pipeline registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            calib_q     <= 1'b0;
            calib_cnt_q <= '0;
            stall_cnt_q <= '0;
            proto_err_q <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            vld_q       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            calib_q     <= calib_d;
            calib_cnt_q <= calib_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            proto_err_q <= proto_err_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_ddr_ui_mem_model.sv
// tb_ddr_ui_mem_model
// Directed bench for ddr_ui_mem_model with default parameters. Inputs change
// on the falling edge, outputs are observed on the falling edge, so every
// observation sees the state left by the preceding rising edge.

module tb_ddr_ui_mem_model;

    localparam int          RD_LAT    = 4;
    localparam logic [2:0]  C_WRITE   = 3'b000;
    localparam logic [2:0]  C_READ    = 3'b001;
    localparam logic [2:0]  C_ILLEGAL = 3'b010;

    logic        clk;
    logic        rst;
    logic [31:0] app_addr;
    logic [2:0]  app_cmd;
    logic        app_en;
    logic [63:0] app_wdf_data;
    logic [31:0] app_wdf_mask;
    logic        app_wdf_end;
    logic        app_wdf_wren;
    logic        init_calib_complete;
    logic        app_rdy;
    logic        app_wdf_rdy;
    logic [63:0] app_rd_data;
    logic        app_rd_data_valid;
    logic        app_rd_data_end;
    logic        proto_err;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int checks      = 0;
    int errors      = 0;
    int stalls_seen = 0;
    int end_bad     = 0;
    logic [63:0] rd_q [$];

    ddr_ui_mem_model dut (
        .clk                 (clk),
        .rst                 (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_wren        (app_wdf_wren),
        .init_calib_complete (init_calib_complete),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .proto_err           (proto_err),
        .wr_count            (wr_count),
        .rd_count            (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every returned read word and any end/valid disagreement.
    always @(negedge clk) begin
        if (app_rd_data_valid === 1'b1) rd_q.push_back(app_rd_data);
        if (app_rd_data_end !== app_rd_data_valid) end_bad++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for calibration; caller is on a falling edge.
    task automatic wait_calib();
        int n = 0;
        while (init_calib_complete !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (init_calib_complete !== 1'b1) begin
            errors++;
            $display("FAIL calib_timeout: init_calib_complete=%b required 1", init_calib_complete);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_calib();
        rd_q.delete();
    endtask

    // Presents one command, holding it through stalls; write data is driven
    // only in the cycle where app_rdy guarantees acceptance. Returns on the
    // falling edge right after the accepting rising edge.
    task automatic issue(input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [31:0] mask,
                         input logic wren, input logic wend);
        logic got = 1'b0;
        for (int n = 0; n < 32 && !got; n++) begin
            app_en       = 1'b1;
            app_cmd      = cmd;
            app_addr     = addr;
            app_wdf_data = wdata;
            app_wdf_mask = mask;
            app_wdf_wren = wren & app_rdy;
            app_wdf_end  = wend & app_rdy;
            got          = app_rdy;
            if (app_rdy !== 1'b1) stalls_seen++;
            @(negedge clk);
        end
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL issue_timeout: cmd %b addr %h never accepted", cmd, addr);
        end
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [63:0] data, output bit seen);
        issue(C_READ, addr, 64'd0, 32'd0, 1'b0, 1'b0);
        seen = 1'b0;
        data = 'x;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (app_rd_data_valid === 1'b1) begin
                seen = 1'b1;
                data = app_rd_data;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // 1: outputs idle in reset, calibration rises exactly 64 edges after
    // release, then app_rdy drops on the 16th cycle of each stall period.
    task automatic test_reset();
        bit early = 1'b0;
        #12;
        checks++;
        if ({init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
             proto_err, wr_count, rd_count, app_rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: calib=%b rdy=%b wdf_rdy=%b vld=%b err=%b wr=%0d rd=%0d data=%h required all 0",
                     init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, proto_err,
                     wr_count, rd_count, app_rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 64 + 16; e++) begin
            @(negedge clk);
            if (e < 64 && (init_calib_complete | app_rdy | app_wdf_rdy) !== 1'b0) early = 1'b1;
            if (e == 64) begin
                checks++;
                if (early) begin
                    errors++;
                    $display("FAIL calib_early: calib/rdy seen high before edge 64, required low");
                end
                checks++;
                if ({init_calib_complete, app_rdy, app_wdf_rdy} !== 3'b111) begin
                    errors++;
                    $display("FAIL calib_edge64: calib/rdy/wdf_rdy=%b required 111",
                             {init_calib_complete, app_rdy, app_wdf_rdy});
                end
            end
            if (e == 64 + 14 || e == 64 + 16) begin
                checks++;
                if (app_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_ready: app_rdy=%b at calib+%0d required 1", app_rdy, e - 64);
                end
            end
            if (e == 64 + 15) begin
                checks++;
                if (app_rdy !== 1'b0 || app_wdf_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_cycle: app_rdy=%b wdf_rdy=%b at calib+15 required 0/1",
                             app_rdy, app_wdf_rdy);
                end
            end
        end
    endtask

    // 2: single write then read, exact read latency and data hold afterwards.
    task automatic test_write_read();
        issue(C_WRITE, 32'h08, 64'h1122334455667788, 32'd0, 1'b1, 1'b1);
        checks++;
        if (wr_count !== 16'd1) begin
            errors++;
            $display("FAIL wr_count_one: got %0d required 1", wr_count);
        end
        issue(C_READ, 32'h08, 64'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < RD_LAT - 1; i++) begin
            checks++;
            if (app_rd_data_valid !== 1'b0) begin
                errors++;
                $display("FAIL rd_early: valid=%b at accept+%0d required 0", app_rd_data_valid, i);
            end
            @(negedge clk);
        end
        checks++;
        if (app_rd_data_valid !== 1'b1 || app_rd_data_end !== 1'b1 ||
            app_rd_data !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL rd_latency: valid=%b end=%b data=%h required 1/1/1122334455667788",
                     app_rd_data_valid, app_rd_data_end, app_rd_data);
        end
        checks++;
        if (rd_count !== 16'd1) begin
            errors++;
            $display("FAIL rd_count_one: got %0d required 1", rd_count);
        end
        @(negedge clk);
        checks++;
        if (app_rd_data_valid !== 1'b0 || app_rd_data !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL rd_hold: valid=%b data=%h required 0/1122334455667788",
                     app_rd_data_valid, app_rd_data);
        end
    endtask

    // 3: low four bytes masked (upper mask bits set but ignored).
    task automatic test_mask();
        logic [63:0] d;
        bit          seen;
        issue(C_WRITE, 32'h10, 64'd0, 32'd0, 1'b1, 1'b1);
        issue(C_WRITE, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FF0F, 1'b1, 1'b1);
        read_word(32'h10, d, seen);
        checks++;
        if (!seen || d !== 64'hFFFF_FFFF_0000_0000) begin
            errors++;
            $display("FAIL byte_mask: seen=%b data=%h required FFFFFFFF00000000", seen, d);
        end
    endtask

    // 4: 200 writes and 200 back-to-back reads through the stall pattern.
    task automatic test_bulk();
        reset_dut();
        stalls_seen = 0;
        end_bad     = 0;
        for (int i = 0; i < 200; i++) begin
            issue(C_WRITE, 32'(i * 8), 64'(i), 32'd0, 1'b1, 1'b1);
        end
        checks++;
        if (wr_count !== 16'd200) begin
            errors++;
            $display("FAIL bulk_wr_count: got %0d required 200", wr_count);
        end
        rd_q.delete();
        for (int i = 0; i < 200; i++) begin
            issue(C_READ, 32'(i * 8), 64'd0, 32'd0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 40 && rd_q.size() < 200; n++) @(negedge clk);
        #1;
        checks++;
        if (rd_q.size() != 200) begin
            errors++;
            $display("FAIL bulk_rd_num: got %0d returns required 200", rd_q.size());
        end
        for (int i = 0; i < 200 && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== 64'(i)) begin
                errors++;
                $display("FAIL bulk_rd_data[%0d]: got %h required %h", i, rd_q[i], 64'(i));
            end
        end
        checks++;
        if (rd_count !== 16'd200 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL bulk_status: rd_count=%0d proto_err=%b required 200/0", rd_count, proto_err);
        end
        // 400 accepts from stall counter 0: 26 full periods of 15 ready + 1 stall.
        checks++;
        if (stalls_seen != 26) begin
            errors++;
            $display("FAIL bulk_stalls: got %0d stall cycles required 26", stalls_seen);
        end
        checks++;
        if (end_bad != 0) begin
            errors++;
            $display("FAIL rd_end_match: %0d cycles with end != valid, required 0", end_bad);
        end
    endtask

    // 5: each protocol violation sets the sticky flag and touches nothing.
    task automatic test_proto_err();
        logic [63:0] d;
        bit          seen;
        issue(C_WRITE, 32'h18, 64'hBAD0_BAD0_BAD0_BAD0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || wr_count !== 16'd200) begin
            errors++;
            $display("FAIL err_no_wren: proto_err=%b wr_count=%0d required 1/200", proto_err, wr_count);
        end
        issue(C_ILLEGAL, 32'h20, 64'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || wr_count !== 16'd200 || rd_count !== 16'd200) begin
            errors++;
            $display("FAIL err_sticky_illegal: err=%b wr=%0d rd=%0d required 1/200/200",
                     proto_err, wr_count, rd_count);
        end
        read_word(32'h18, d, seen);
        checks++;
        if (!seen || d !== 64'd3) begin
            errors++;
            $display("FAIL err_write_dropped: seen=%b data=%h required 3", seen, d);
        end

        reset_dut();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset_clear: proto_err=%b required 0", proto_err);
        end
        issue(C_ILLEGAL, 32'h20, 64'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || wr_count !== 16'd0 || rd_count !== 16'd0) begin
            errors++;
            $display("FAIL err_illegal_cmd: err=%b wr=%0d rd=%0d required 1/0/0",
                     proto_err, wr_count, rd_count);
        end

        reset_dut();
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = 64'h5555_5555_5555_5555;
        @(negedge clk);
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL err_orphan_wren: err=%b wr=%0d required 1/0", proto_err, wr_count);
        end

        reset_dut();
        issue(C_WRITE, 32'h18, 64'hBAD1_BAD1_BAD1_BAD1, 32'd0, 1'b1, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL err_end_mismatch: err=%b wr=%0d required 1/0", proto_err, wr_count);
        end
    endtask

    // 6: reset while reads are in flight drops them; the array survives and
    // addresses alias above the index bits.
    task automatic test_reset_inflight();
        logic [63:0] d;
        bit          seen;
        reset_dut();
        issue(C_WRITE, 32'h800, 64'hDEAD_BEEF_CAFE_F00D, 32'd0, 1'b1, 1'b1);
        rd_q.delete();
        issue(C_READ, 32'h000, 64'd0, 32'd0, 1'b0, 1'b0);
        issue(C_READ, 32'h800, 64'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({init_calib_complete, app_rdy, app_rd_data_valid} !== 3'b000 || rd_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: calib/rdy/valid=%b rd_count=%0d required 000/0",
                     {init_calib_complete, app_rdy, app_rd_data_valid}, rd_count);
        end
        repeat (10) @(negedge clk);
        rst = 1'b0;
        wait_calib();
        repeat (10) @(negedge clk);
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL inflight_dropped: got %0d valid pulses required 0", rd_q.size());
        end
        read_word(32'h000, d, seen);
        checks++;
        if (!seen || d !== 64'hDEAD_BEEF_CAFE_F00D) begin
            errors++;
            $display("FAIL mem_retained: seen=%b data=%h required DEADBEEFCAFEF00D", seen, d);
        end
        read_word(32'h800, d, seen);
        checks++;
        if (!seen || d !== 64'hDEAD_BEEF_CAFE_F00D) begin
            errors++;
            $display("FAIL alias_800: seen=%b data=%h required DEADBEEFCAFEF00D", seen, d);
        end
        read_word(32'h80F, d, seen);
        checks++;
        if (!seen || d !== 64'd1) begin
            errors++;
            $display("FAIL alias_80F: seen=%b data=%h required 1", seen, d);
        end
    endtask

    initial begin
        rst          = 1'b1;
        app_addr     = '0;
        app_cmd      = '0;
        app_en       = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_end  = 1'b0;
        app_wdf_wren = 1'b0;

        test_reset();
        test_write_read();
        test_mask();
        test_bulk();
        test_proto_err();
        test_reset_inflight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
